mca_window_sequencer: RTL and testbench

Front-end sequencer for the multi-clock FIR adder. It collects the N-bit control vectors streaming from the control-bounded ADC into a K-deep sliding window and downsamples by OSR. On each output instant it freezes a snapshot of the window onto the adder's S_matrix input, pulses start, and waits the adder's fixed latency. It then captures the adder's sample and presents it with a one-cycle valid.

---
 rtl/mca_window_sequencer_pkg.sv | 10 +
 rtl/mca_window_shift.sv | 35 +++
 rtl/mca_window_sequencer.sv | 101 ++++++++++
 tb/tb_mca_window_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mca_window_sequencer_pkg.sv
// mca_window_sequencer_pkg: shared types and helpers for the FIR adder front-end sequencer
// Contents: FSM state enum, control-vector type, decimation counter width helper.
package mca_window_sequencer_pkg;
  typedef enum logic {IDLE, BUSY} state_e;
  localparam int CTRL_N_MAX = 8;
  typedef logic [CTRL_N_MAX-1:0] ctrl_vec_t;
  function automatic int dec_width(input int osr);
    return osr > 1 ? $clog2(osr) : 1;
  endfunction
endpackage

// File: rtl/mca_window_shift.sv
// mca_window_shift: K x N sliding window of control vectors with saturating fill counter
// Ports: clk, reset (sync, active-high), s_valid_i/s_in_i incoming vector,
//        win_d_o post-shift window (index 0 newest), full_d_o fill equals K after this shift.
module mca_window_shift
  import mca_window_sequencer_pkg::*;
#(
  parameter int K = 256,
  parameter int N = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid_i,
  input  logic [N-1:0]        s_in_i,
  output logic [K-1:0][N-1:0] win_d_o,
  output logic                full_d_o
);
  localparam int FW = $clog2(K + 1);
  logic [K-1:0][N-1:0] win_q;
  logic [FW-1:0]       fill_q, fill_d;
  // Post-shift values are exported so a launch can snapshot the window on the same edge.
  always_comb begin
    win_d_o  = s_valid_i ? {win_q[K-2:0], s_in_i} : win_q;
    fill_d   = s_valid_i && fill_q != FW'(K) ? fill_q + 1'b1 : fill_q;
    full_d_o = fill_d == FW'(K);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d_o;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/mca_window_sequencer.sv
// mca_window_sequencer: windows and decimates ADC control vectors, launches the FIR adder, captures its sample
// Ports: clk, reset (sync, active-high), s_valid/s_in vector stream, clear_overrun,
//        S_matrix frozen window, start launch pulse, sample_in adder result,
//        out_sample/out_valid decimated output, overrun sticky drop flag.
// Option: MCA_OVERRUN_COUNT_EN adds overrun_count, a saturating 16-bit dropped-launch counter.
module mca_window_sequencer
  import mca_window_sequencer_pkg::*;
#(
  parameter int K                 = 256,
  parameter int N                 = 8,
  parameter int WIDTH_COEFFICIENT = 32,
  parameter int OSR               = 16,
  parameter int ADDER_LATENCY     = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                s_valid,
  input  logic [N-1:0]                        s_in,
  input  logic                                clear_overrun,
  output logic [K-1:0][N-1:0]                 S_matrix,
  output logic                                start,
  input  logic signed [WIDTH_COEFFICIENT-1:0] sample_in,
  output logic signed [WIDTH_COEFFICIENT-1:0] out_sample,
  output logic                                out_valid,
  output logic                                overrun
`ifdef MCA_OVERRUN_COUNT_EN
  , output logic [15:0]                       overrun_count
`endif
);
  localparam int DW = dec_width(OSR);
  localparam int LW = $clog2(ADDER_LATENCY + 1);
  logic [K-1:0][N-1:0]                 win_nxt, snap_q, snap_d;
  logic                                full_nxt, launch, cap, accept, drop;
  state_e                              state_q, state_d;
  logic [DW-1:0]                       dec_q, dec_d;
  logic [LW-1:0]                       lat_q, lat_d;
  logic                                start_q, valid_q, ovr_q, ovr_d;
  logic signed [WIDTH_COEFFICIENT-1:0] sample_q, sample_d;

  mca_window_shift #(.K(K), .N(N)) u_shift (
    .clk      (clk),
    .reset    (reset),
    .s_valid_i(s_valid),
    .s_in_i   (s_in),
    .win_d_o  (win_nxt),
    .full_d_o (full_nxt)
  );

  // A launch is the vector seeing dec==0 once the window is full, so the K-th vector launches.
  // The capture cycle frees the adder, so a launch landing on it is accepted.
  always_comb begin
    dec_d    = s_valid && full_nxt ? (dec_q == DW'(OSR - 1) ? '0 : dec_q + 1'b1) : dec_q;
    launch   = s_valid && full_nxt && dec_q == '0;
    cap      = state_q == BUSY && lat_q == LW'(1);
    accept   = launch && (state_q == IDLE || cap);
    drop     = launch && !accept;
    state_d  = accept ? BUSY : cap ? IDLE : state_q;
    lat_d    = accept ? LW'(ADDER_LATENCY) : state_q == BUSY ? lat_q - 1'b1 : lat_q;
    snap_d   = accept ? win_nxt : snap_q;
    sample_d = cap ? sample_in : sample_q;
    ovr_d    = drop || (ovr_q && !clear_overrun);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      dec_q    <= '0;
      lat_q    <= '0;
      snap_q   <= '0;
      start_q  <= 1'b0;
      sample_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      dec_q    <= dec_d;
      lat_q    <= lat_d;
      snap_q   <= snap_d;
      start_q  <= accept;
      sample_q <= sample_d;
      valid_q  <= cap;
      ovr_q    <= ovr_d;
    end
  end

  assign S_matrix   = snap_q;
  assign start      = start_q;
  assign out_sample = sample_q;
  assign out_valid  = valid_q;
  assign overrun    = ovr_q;

`ifdef MCA_OVERRUN_COUNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = drop ? (cnt_q == 16'hFFFF ? cnt_q : cnt_q + 1'b1) : clear_overrun ? '0 : cnt_q;
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign overrun_count = cnt_q;
`endif
endmodule

// File: tb/tb_mca_window_sequencer.sv
// tb_mca_window_sequencer: directed self-checking bench, K=8 N=3 L=4 with OSR=4 (a) and OSR=1 (b)
module tb_mca_window_sequencer;
  typedef logic [7:0][2:0] win_t;
  logic               clk = 1'b0;
  logic               reset, s_valid, clear_overrun;
  logic [2:0]         s_in;
  logic signed [31:0] sample_in;
  win_t               sm_a, sm_b;
  logic               start_a, start_b, vld_a, vld_b, ov_a, ov_b;
  logic signed [31:0] os_a, os_b;
`ifdef MCA_OVERRUN_COUNT_EN
  logic [15:0]        cnt_a, cnt_b;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mca_window_sequencer #(.K(8), .N(3), .WIDTH_COEFFICIENT(32), .OSR(4), .ADDER_LATENCY(4)) u_a (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_in(s_in), .clear_overrun(clear_overrun),
    .S_matrix(sm_a), .start(start_a), .sample_in(sample_in), .out_sample(os_a),
    .out_valid(vld_a), .overrun(ov_a)
`ifdef MCA_OVERRUN_COUNT_EN
    , .overrun_count(cnt_a)
`endif
  );

  mca_window_sequencer #(.K(8), .N(3), .WIDTH_COEFFICIENT(32), .OSR(1), .ADDER_LATENCY(4)) u_b (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_in(s_in), .clear_overrun(clear_overrun),
    .S_matrix(sm_b), .start(start_b), .sample_in(sample_in), .out_sample(os_b),
    .out_valid(vld_b), .overrun(ov_b)
`ifdef MCA_OVERRUN_COUNT_EN
    , .overrun_count(cnt_b)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic win_t snap(input int j);
    win_t r;
    for (int i = 0; i < 8; i++) r[i] = 3'((j - i) % 8);
    return r;
  endfunction

  task automatic restart();
    reset = 1'b1;
    s_valid = 1'b0;
    clear_overrun = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    s_valid = 1'b0;
    clear_overrun = 1'b0;
    s_in = '0;
    sample_in = 32'sd77;
    step();
    step();
    checks += 6;
    if (sm_a !== '0) begin errors++; $display("FAIL reset_smatrix: got %h expected 0", sm_a); end
    if (start_a !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", start_a); end
    if (os_a !== '0) begin errors++; $display("FAIL reset_out_sample: got %0d expected 0", os_a); end
    if (vld_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", vld_a); end
    if (ov_a !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b expected 0", ov_a); end
    if ({sm_b, start_b, os_b, vld_b, ov_b} !== '0) begin errors++; $display("FAIL reset_b_outputs: got nonzero expected 0"); end
`ifdef MCA_OVERRUN_COUNT_EN
    checks++;
    if (cnt_a !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cnt_a); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_fill_and_launch();
    win_t exp_sm = '0;
    win_t first = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic es, ev;
    restart();
    s_valid = 1'b1;
    for (int j = 0; j < 24; j++) begin
      s_in = 3'(j % 8);
      sample_in = 32'(100 + j);
      step();
      es = j >= 7 && (j - 7) % 4 == 0;
      ev = j >= 11 && (j - 11) % 4 == 0;
      if (es) exp_sm = snap(j);
      checks += 4;
      if (start_a !== es) begin errors++; $display("FAIL start_a j=%0d: got %b expected %b", j, start_a, es); end
      if (vld_a !== ev) begin errors++; $display("FAIL out_valid_a j=%0d: got %b expected %b", j, vld_a, ev); end
      if (sm_a !== exp_sm) begin errors++; $display("FAIL smatrix_a j=%0d: got %h expected %h", j, sm_a, exp_sm); end
      if (ov_a !== 1'b0) begin errors++; $display("FAIL overrun_a j=%0d: got %b expected 0", j, ov_a); end
      if (ev) begin
        checks++;
        if (os_a !== 32'(100 + j)) begin errors++; $display("FAIL out_sample_a j=%0d: got %0d expected %0d", j, os_a, 100 + j); end
      end
      if (j == 7) begin
        checks++;
        if (sm_a !== first) begin errors++; $display("FAIL first_smatrix: got %h expected %h", sm_a, first); end
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_osr1();
    win_t exp_sm = '0;
    logic es, eo;
    int exp_cnt = 0;
    restart();
    s_valid = 1'b1;
    for (int j = 0; j < 21; j++) begin
      s_in = 3'(j % 8);
      sample_in = 32'(-j);
      step();
      es = j >= 7 && (j - 7) % 4 == 0;
      eo = j >= 8;
      if (es) exp_sm = snap(j);
      if (j >= 8 && !es) exp_cnt++;
      checks += 3;
      if (start_b !== es) begin errors++; $display("FAIL start_b j=%0d: got %b expected %b", j, start_b, es); end
      if (ov_b !== eo) begin errors++; $display("FAIL overrun_b j=%0d: got %b expected %b", j, ov_b, eo); end
      if (sm_b !== exp_sm) begin errors++; $display("FAIL smatrix_b j=%0d: got %h expected %h", j, sm_b, exp_sm); end
`ifdef MCA_OVERRUN_COUNT_EN
      checks++;
      if (cnt_b !== 16'(exp_cnt)) begin errors++; $display("FAIL count_b j=%0d: got %0d expected %0d", j, cnt_b, exp_cnt); end
`endif
    end
    s_valid = 1'b0;
  endtask

  task automatic test_clear_overrun();
    restart();
    s_valid = 1'b1;
    for (int j = 0; j < 9; j++) begin
      s_in = 3'(j);
      step();
    end
    checks++;
    if (ov_b !== 1'b1) begin errors++; $display("FAIL clr_pre_set: got %b expected 1", ov_b); end
    s_valid = 1'b0;
    clear_overrun = 1'b1;
    step();
    checks++;
    if (ov_b !== 1'b0) begin errors++; $display("FAIL clr_no_drop: got %b expected 0", ov_b); end
`ifdef MCA_OVERRUN_COUNT_EN
    checks++;
    if (cnt_b !== 16'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", cnt_b); end
`endif
    s_valid = 1'b1;
    s_in = 3'd5;
    step();
    checks++;
    if (ov_b !== 1'b1) begin errors++; $display("FAIL clr_with_drop: got %b expected 1", ov_b); end
`ifdef MCA_OVERRUN_COUNT_EN
    checks++;
    if (cnt_b !== 16'd1) begin errors++; $display("FAIL clr_count_tie: got %0d expected 1", cnt_b); end
`endif
    s_valid = 1'b0;
    clear_overrun = 1'b0;
    step();
    checks++;
    if (ov_b !== 1'b1) begin errors++; $display("FAIL clr_sticky: got %b expected 1", ov_b); end
  endtask

  task automatic test_reset_mid();
    logic es;
    restart();
    s_valid = 1'b1;
    for (int j = 0; j < 9; j++) begin
      s_in = 3'(j % 8);
      sample_in = 32'(200 + j);
      step();
      if (j == 7) begin
        checks++;
        if (start_a !== 1'b1) begin errors++; $display("FAIL mid_start: got %b expected 1", start_a); end
      end
    end
    reset = 1'b1;
    step();
    checks += 2;
    if ({sm_a, start_a, os_a, vld_a, ov_a} !== '0) begin errors++; $display("FAIL mid_reset_a: got sm=%h st=%b os=%0d v=%b ov=%b expected 0", sm_a, start_a, os_a, vld_a, ov_a); end
    if ({sm_b, start_b, os_b, vld_b, ov_b} !== '0) begin errors++; $display("FAIL mid_reset_b: got sm=%h st=%b os=%0d v=%b ov=%b expected 0", sm_b, start_b, os_b, vld_b, ov_b); end
    reset = 1'b0;
    for (int j = 10; j < 21; j++) begin
      s_in = 3'(j % 8);
      sample_in = 32'(200 + j);
      step();
      es = j == 17;
      checks += 3;
      if (start_a !== es) begin errors++; $display("FAIL mid_restart j=%0d: got %b expected %b", j, start_a, es); end
      if (vld_a !== 1'b0) begin errors++; $display("FAIL mid_no_valid j=%0d: got %b expected 0", j, vld_a); end
      if (os_a !== '0) begin errors++; $display("FAIL mid_out_sample j=%0d: got %0d expected 0", j, os_a); end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_and_launch();
    test_osr1();
    test_clear_overrun();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
